vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 16 +
 rtl/vram_write_fifo.sv | 78 +++++++
 rtl/vram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default constants for the VRAM arbiter.
// The slot-owner enum names who drives the VRAM port in the next cycle.
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GPU  = 2'd1,
        CPU  = 2'd2
    } slot_e;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int DATA_W           = 8;

endpackage

// File: rtl/vram_write_fifo.sv
// CPU write buffer: a small synchronous FIFO with occupancy count.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored. DEPTH must be a power of two so that the
// pointers wrap naturally.
import vram_arbiter_pkg::*;

module vram_write_fifo #(
    parameter int W     = DEF_ADDR_W + DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_B,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointer, count and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_B) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM port arbiter between a GPU fetch stream and a buffered CPU write path.
// The GPU normally owns the port; buffered CPU writes drain when the GPU is
// idle. Optional starvation guard, enabled by defining
// VRAM_ARBITER_STARVE_GUARD_EN, steals one slot for the CPU after
// STARVE_LIMIT consecutive GPU grants with the write buffer full.
//
// Handshake: gpu_rd_grant is asserted in the same cycle as gpu_rd_req when
// the request is accepted; data returns with gpu_rd_data_valid two cycles
// later. cpu_wr_valid is a one-cycle push with no back-pressure: writes
// presented while cpu_wr_full and no slot drain are dropped and flagged.
import vram_arbiter_pkg::*;

module vram_arbiter #(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              gpu_clk,
    input  logic              rst_B,
    input  logic              cpu_wr_valid,
    input  logic [ADDR_W-1:0] cpu_wr_address,
    input  logic [7:0]        cpu_wr_data,
    output logic              cpu_wr_full,
    output logic              overflow,
    input  logic              clr_overflow,
    input  logic              gpu_rd_req,
    input  logic [ADDR_W-1:0] gpu_rd_address,
    output logic              gpu_rd_grant,
    output logic [7:0]        gpu_rd_data,
    output logic              gpu_rd_data_valid,
    output logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_wdata,
    output logic              vram_write_enable,
    input  logic [7:0]        vram_rdata,
    output slot_e             dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    slot_e             slot_q, slot_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]        vram_wdata_q, vram_wdata_d;
    logic              vram_we_q, vram_we_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;

    logic              force_write;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_head;
    logic              wr_drop;

    vram_write_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (gpu_clk),
        .rst_B (rst_B),
        .push  (cpu_wr_valid),
        .pop   (fifo_pop),
        .wdata ({cpu_wr_address, cpu_wr_data}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cpu_wr_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign gpu_rd_grant = rst_B & gpu_rd_req & ~force_write;
    assign fifo_pop     = (slot_d == CPU);
    assign wr_drop      = cpu_wr_valid & fifo_full & ~fifo_pop;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

    // A forced write fires once the count hits the limit; no grant occurs
    // in that cycle, so the counter falls back to zero on its own.
    assign force_write = (starve_cnt_q == SC_W'(STARVE_LIMIT));

    // Count consecutive GPU grants taken while the buffer sits full.
    always_comb begin
        starve_cnt_d = '0;
        if (!force_write && fifo_full && gpu_rd_grant) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge gpu_clk) begin
        if (!rst_B) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_write = 1'b0;
`endif

    // Slot owner selection and the VRAM port values it implies next cycle.
    always_comb begin
        slot_d       = IDLE;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        vram_we_d    = 1'b0;
        if (gpu_rd_grant) begin
            slot_d = GPU;
        end else if (!fifo_empty) begin
            slot_d = CPU;
        end
        case (slot_d)
            GPU: begin
                vram_addr_d = gpu_rd_address;
            end
            CPU: begin
                vram_addr_d  = fifo_head[ENT_W-1:DATA_W];
                vram_wdata_d = fifo_head[DATA_W-1:0];
                vram_we_d    = 1'b1;
            end
            default: begin
                vram_addr_d = vram_addr_q;
            end
        endcase
    end

    // Read-return pipeline and sticky overflow; a new drop beats a clear.
    always_comb begin
        rd_pend_d  = gpu_rd_grant;
        rd_valid_d = rd_pend_q;
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (wr_drop) begin
            overflow_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge gpu_clk) begin
        if (!rst_B) begin
            slot_q       <= IDLE;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
            vram_we_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
            vram_we_q    <= vram_we_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign vram_address      = vram_addr_q;
    assign vram_wdata        = vram_wdata_q;
    assign vram_write_enable = vram_we_q;
    assign gpu_rd_data       = vram_rdata;
    assign gpu_rd_data_valid = rd_valid_q;
    assign overflow          = overflow_q;
    assign dbg_state         = slot_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter. Build with VRAM_ARBITER_STARVE_GUARD_EN
// defined to exercise the starvation-guard scenario instead of the
// GPU-always-wins scenario.
import vram_arbiter_pkg::*;

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_B;
    logic        cpu_wr_valid;
    logic [11:0] cpu_wr_address;
    logic [7:0]  cpu_wr_data;
    logic        cpu_wr_full;
    logic        overflow;
    logic        clr_overflow;
    logic        gpu_rd_req;
    logic [11:0] gpu_rd_address;
    logic        gpu_rd_grant;
    logic [7:0]  gpu_rd_data;
    logic        gpu_rd_data_valid;
    logic [11:0] vram_address;
    logic [7:0]  vram_wdata;
    logic        vram_write_enable;
    logic [7:0]  vram_rdata;
    slot_e       dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W       (12),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .gpu_clk           (clk),
        .rst_B             (rst_B),
        .cpu_wr_valid      (cpu_wr_valid),
        .cpu_wr_address    (cpu_wr_address),
        .cpu_wr_data       (cpu_wr_data),
        .cpu_wr_full       (cpu_wr_full),
        .overflow          (overflow),
        .clr_overflow      (clr_overflow),
        .gpu_rd_req        (gpu_rd_req),
        .gpu_rd_address    (gpu_rd_address),
        .gpu_rd_grant      (gpu_rd_grant),
        .gpu_rd_data       (gpu_rd_data),
        .gpu_rd_data_valid (gpu_rd_data_valid),
        .vram_address      (vram_address),
        .vram_wdata        (vram_wdata),
        .vram_write_enable (vram_write_enable),
        .vram_rdata        (vram_rdata),
        .dbg_state         (dbg_state)
    );

    // Synchronous-read VRAM model: data = low address byte xor 0x67.
    always @(posedge clk) begin
        vram_rdata <= vram_address[7:0] ^ 8'h67;
    end

    // Record every VRAM write as {address, data}.
    always @(negedge clk) begin
        if (vram_write_enable === 1'b1) obs_q.push_back({vram_address, vram_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_and_compare(input string name);
        gpu_rd_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s_order[%0d]: got %h, expected %h", name, i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic push_n(input int n, input logic [11:0] base_a, input logic [7:0] base_d, input int keep);
        for (int i = 0; i < n; i++) begin
            cpu_wr_valid   = 1'b1;
            cpu_wr_address = base_a + 12'(i);
            cpu_wr_data    = base_d + 8'(i);
            if (i < keep) exp_q.push_back({base_a + 12'(i), base_d + 8'(i)});
            tick();
        end
        cpu_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_B          = 1'b0;
        cpu_wr_valid   = 1'b0;
        cpu_wr_address = '0;
        cpu_wr_data    = '0;
        clr_overflow   = 1'b0;
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h055;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (gpu_rd_grant !== 1'b0) begin failures++; $display("FAIL rst_grant: got %b, expected 0", gpu_rd_grant); end
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we: got %b, expected 0", vram_write_enable); end
        checks++; if (vram_address !== 12'h000) begin failures++; $display("FAIL rst_addr: got %h, expected 000", vram_address); end
        checks++; if (vram_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata: got %h, expected 00", vram_wdata); end
        checks++; if (gpu_rd_data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, expected 0", gpu_rd_data_valid); end
        checks++; if (cpu_wr_full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b, expected 0", cpu_wr_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b, expected 0", overflow); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d, expected IDLE", dbg_state); end
        tick();
        rst_B      = 1'b1;
        gpu_rd_req = 1'b0;
        repeat (2) tick();
        obs_q.delete();
    endtask

    task automatic test_cpu_write();
        cpu_wr_valid   = 1'b1;
        cpu_wr_address = 12'h4A5;
        cpu_wr_data    = 8'h3C;
        @(negedge clk);
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL wr_push_cycle_we: got %b, expected 0", vram_write_enable); end
        tick();
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL wr_plus1_we: got %b, expected 0", vram_write_enable); end
        tick();
        @(negedge clk);
        checks++; if (vram_write_enable !== 1'b1) begin failures++; $display("FAIL wr_plus2_we: got %b, expected 1", vram_write_enable); end
        checks++; if (vram_address !== 12'h4A5) begin failures++; $display("FAIL wr_plus2_addr: got %h, expected 4A5", vram_address); end
        checks++; if (vram_wdata !== 8'h3C) begin failures++; $display("FAIL wr_plus2_data: got %h, expected 3C", vram_wdata); end
        tick();
        @(negedge clk);
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL wr_plus3_we: got %b, expected 0", vram_write_enable); end
        tick();
        obs_q.delete();
    endtask

    task automatic test_gpu_read();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h010;
        @(negedge clk);
        checks++; if (gpu_rd_grant !== 1'b1) begin failures++; $display("FAIL rd_grant: got %b, expected 1", gpu_rd_grant); end
        tick();
        @(negedge clk);
        checks++; if (vram_address !== 12'h010) begin failures++; $display("FAIL rd_addr: got %h, expected 010", vram_address); end
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL rd_we: got %b, expected 0", vram_write_enable); end
        checks++; if (gpu_rd_data_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_early: got %b, expected 0", gpu_rd_data_valid); end
        checks++; if (dbg_state !== GPU) begin failures++; $display("FAIL rd_state: got %0d, expected GPU", dbg_state); end
        tick();
        @(negedge clk);
        checks++; if (gpu_rd_data_valid !== 1'b1) begin failures++; $display("FAIL rd_valid: got %b, expected 1", gpu_rd_data_valid); end
        checks++; if (gpu_rd_data !== 8'h77) begin failures++; $display("FAIL rd_data: got %h, expected 77", gpu_rd_data); end
        tick();
        gpu_rd_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (gpu_rd_data_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_late: got %b, expected 0", gpu_rd_data_valid); end
        tick();
    endtask

`ifndef VRAM_ARBITER_STARVE_GUARD_EN
    task automatic test_gpu_priority();
        obs_q.delete();
        exp_q.delete();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h020;
        push_n(5, 12'h100, 8'hA0, 4);
        @(negedge clk);
        checks++; if (cpu_wr_full !== 1'b1) begin failures++; $display("FAIL prio_full: got %b, expected 1", cpu_wr_full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL prio_ovf: got %b, expected 1", overflow); end
        repeat (12) tick();
        @(negedge clk);
        checks++; if (gpu_rd_grant !== 1'b1) begin failures++; $display("FAIL prio_grant: got %b, expected 1", gpu_rd_grant); end
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL prio_no_write: got %0d writes, expected 0", obs_q.size()); end
        tick();
        drain_and_compare("prio_drain");
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL prio_ovf_sticky: got %b, expected 1", overflow); end
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL prio_ovf_clr: got %b, expected 0", overflow); end
        tick();
    endtask
`else
    task automatic test_starve_guard();
        int lows;
        int low_at;
        lows   = 0;
        low_at = -1;
        obs_q.delete();
        exp_q.delete();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h020;
        push_n(5, 12'h100, 8'hA0, 4);
        // Buffer is full from the fifth push cycle; eight grants later the
        // ninth full cycle is the forced one, which is index 7 here.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gpu_rd_grant !== 1'b1) begin
                lows++;
                low_at = k;
            end
            tick();
        end
        checks++; if (lows !== 1) begin failures++; $display("FAIL starve_low_cycles: got %0d, expected 1", lows); end
        checks++; if (low_at !== 7) begin failures++; $display("FAIL starve_low_at: got %0d, expected 7", low_at); end
        checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL starve_one_write: got %0d, expected 1", obs_q.size()); end
        drain_and_compare("starve_drain");
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL starve_ovf_clr: got %b, expected 0", overflow); end
        tick();
    endtask
`endif

    task automatic test_full_push_pop();
        obs_q.delete();
        exp_q.delete();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h030;
        push_n(4, 12'h200, 8'h10, 4);
        gpu_rd_req     = 1'b0;
        cpu_wr_valid   = 1'b1;
        cpu_wr_address = 12'h204;
        cpu_wr_data    = 8'h14;
        exp_q.push_back({12'h204, 8'h14});
        @(negedge clk);
        checks++; if (cpu_wr_full !== 1'b1) begin failures++; $display("FAIL fpp_full_before: got %b, expected 1", cpu_wr_full); end
        tick();
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (cpu_wr_full !== 1'b1) begin failures++; $display("FAIL fpp_full_after: got %b, expected 1", cpu_wr_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf: got %b, expected 0", overflow); end
        tick();
        drain_and_compare("fpp_drain");
    endtask

    task automatic test_drop_vs_clear();
        obs_q.delete();
        exp_q.delete();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h040;
        push_n(4, 12'h300, 8'h50, 4);
        cpu_wr_valid   = 1'b1;
        cpu_wr_address = 12'h304;
        cpu_wr_data    = 8'h54;
        clr_overflow   = 1'b1;
        tick();
        cpu_wr_valid = 1'b0;
        clr_overflow = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL dvc_set_wins: got %b, expected 1", overflow); end
        tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL dvc_clear: got %b, expected 0", overflow); end
        tick();
        drain_and_compare("dvc_drain");
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        gpu_rd_req     = 1'b1;
        gpu_rd_address = 12'h050;
        push_n(3, 12'h400, 8'h60, 0);
        tick();
        rst_B = 1'b0;
        @(negedge clk);
        checks++; if (gpu_rd_grant !== 1'b0) begin failures++; $display("FAIL rmid_grant: got %b, expected 0", gpu_rd_grant); end
        tick();
        rst_B      = 1'b1;
        gpu_rd_req = 1'b0;
        @(negedge clk);
        checks++; if (vram_write_enable !== 1'b0) begin failures++; $display("FAIL rmid_we: got %b, expected 0", vram_write_enable); end
        checks++; if (vram_address !== 12'h000) begin failures++; $display("FAIL rmid_addr: got %h, expected 000", vram_address); end
        checks++; if (gpu_rd_data_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b, expected 0", gpu_rd_data_valid); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rmid_state: got %0d, expected IDLE", dbg_state); end
        repeat (6) tick();
        @(negedge clk);
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL rmid_no_write: got %0d writes, expected 0", obs_q.size()); end
        checks++; if (cpu_wr_full !== 1'b0) begin failures++; $display("FAIL rmid_full: got %b, expected 0", cpu_wr_full); end
        checks++; if (gpu_rd_data_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_late: got %b, expected 0", gpu_rd_data_valid); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL rmid_state_late: got %0d, expected IDLE", dbg_state); end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_gpu_read();
`ifndef VRAM_ARBITER_STARVE_GUARD_EN
        test_gpu_priority();
`else
        test_starve_guard();
`endif
        test_full_push_pop();
        test_drop_vs_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
